uart_sample_rx: RTL



---
 rtl/uart_sample_rx.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_sample_rx.sv
// UART 8N1 receiver and frame decoder: HDR0 HDR1, eight payload bytes (four big-endian samples), XOR checksum.
// Optional macro UART_RX_TIMEOUT_EN abandons a stalled partial frame after 20 idle bit times.
module uart_sample_rx #(
  parameter int unsigned W            = 16,
  parameter int unsigned CLKS_PER_BIT = 12,
  parameter logic [7:0]  HDR0         = 8'hCA,
  parameter logic [7:0]  HDR1         = 8'hFE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_i,
  output logic signed [W-1:0] out0,
  output logic signed [W-1:0] out1,
  output logic signed [W-1:0] out2,
  output logic signed [W-1:0] out3,
  output logic                valid,
  output logic                frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned NB = 8;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bit_state_t;
  typedef enum logic [1:0] {F_SYNC0, F_SYNC1, F_PAYLOAD, F_CHECK} frame_state_t;

  logic rx_meta, rxs;

  bit_state_t    bit_state, bit_state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          byte_stb, byte_stb_n;
  logic          fault, fault_n;
  logic          cnt_done_c;

  frame_state_t       frame_state, frame_state_n;
  logic [2:0]         k, k_n;
  logic [7:0]         chk, chk_n;
  logic [NB-1:0][7:0] stg, stg_n;
  logic [W-1:0]       out0_n, out1_n, out2_n, out3_n;
  logic               valid_n, frame_err_n;
  logic               timeout_c;

  // Two-flop synchronizer; idle-high line resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  assign cnt_done_c = (cnt == '0);

  // Bit FSM: mid-bit sampling of start, eight data bits and stop.
  always_comb begin
    bit_state_n = bit_state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    byte_stb_n  = 1'b0;
    fault_n     = 1'b0;
    unique case (bit_state)
      B_IDLE: begin
        if (!rxs) begin
          cnt_n       = HALF_LOAD;
          bit_state_n = B_START;
        end
      end
      B_START: begin
        if (cnt_done_c) begin
          if (!rxs) begin
            bit_state_n = B_DATA;
            cnt_n       = FULL_LOAD;
            idx_n       = '0;
          end else begin
            bit_state_n = B_IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      B_DATA: begin
        if (cnt_done_c) begin
          shreg_n = {rxs, shreg[7:1]};
          cnt_n   = FULL_LOAD;
          if (idx == 3'd7) bit_state_n = B_STOP;
          else             idx_n       = idx + 3'd1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      B_STOP: begin
        if (cnt_done_c) begin
          if (rxs) begin
            byte_stb_n  = 1'b1;
            bit_state_n = B_IDLE;
          end else begin
            fault_n     = 1'b1;
            bit_state_n = B_BREAK;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      B_BREAK: begin
        if (rxs) bit_state_n = B_IDLE;
      end
      default: bit_state_n = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_state <= B_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      bit_state <= bit_state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      byte_stb  <= byte_stb_n;
      fault     <= fault_n;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(20 * CLKS_PER_BIT);
  logic [15:0] idle_cnt;

  // Counts line-idle cycles inside a partially received frame.
  always_ff @(posedge clk) begin
    if (rst || byte_stb || frame_state == F_SYNC0 || timeout_c) idle_cnt <= '0;
    else if (bit_state == B_IDLE)                               idle_cnt <= idle_cnt + 16'd1;
  end

  assign timeout_c = (frame_state != F_SYNC0) && (bit_state == B_IDLE) &&
                     (idle_cnt == TO_LIMIT - 16'd1);
`else
  assign timeout_c = 1'b0;
`endif

  // Frame FSM: header sync, payload staging, checksum compare.
  always_comb begin
    frame_state_n = frame_state;
    k_n           = k;
    chk_n         = chk;
    stg_n         = stg;
    out0_n        = out0;
    out1_n        = out1;
    out2_n        = out2;
    out3_n        = out3;
    valid_n       = 1'b0;
    frame_err_n   = 1'b0;
    if (fault) begin
      frame_err_n   = (frame_state == F_PAYLOAD) || (frame_state == F_CHECK);
      stg_n         = '0;
      frame_state_n = F_SYNC0;
    end else if (byte_stb) begin
      unique case (frame_state)
        F_SYNC0: begin
          if (shreg == HDR0) frame_state_n = F_SYNC1;
        end
        F_SYNC1: begin
          if (shreg == HDR1) begin
            frame_state_n = F_PAYLOAD;
            k_n           = '0;
            chk_n         = '0;
          end else if (shreg != HDR0) begin
            frame_state_n = F_SYNC0;
          end
        end
        F_PAYLOAD: begin
          stg_n[k] = shreg;
          chk_n    = chk ^ shreg;
          k_n      = k + 3'd1;
          if (k == 3'd7) frame_state_n = F_CHECK;
        end
        F_CHECK: begin
          if (shreg == chk) begin
            out0_n  = W'({stg[0], stg[1]});
            out1_n  = W'({stg[2], stg[3]});
            out2_n  = W'({stg[4], stg[5]});
            out3_n  = W'({stg[6], stg[7]});
            valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
          frame_state_n = F_SYNC0;
        end
        default: frame_state_n = F_SYNC0;
      endcase
    end else if (timeout_c) begin
      frame_err_n   = 1'b1;
      stg_n         = '0;
      frame_state_n = F_SYNC0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_state <= F_SYNC0;
      k           <= '0;
      chk         <= '0;
      stg         <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_state <= frame_state_n;
      k           <= k_n;
      chk         <= chk_n;
      stg         <= stg_n;
      out0        <= out0_n;
      out1        <= out1_n;
      out2        <= out2_n;
      out3        <= out3_n;
      valid       <= valid_n;
      frame_err   <= frame_err_n;
    end
  end

endmodule
